// File: rtl/toll_lane_arbiter.sv
// Round-robin arbiter sharing one toll-tag reader between three ETC lanes.
// Define TOLL_TIMEOUT_EN to build the WAIT timeout counter and its forced-fail path.
module toll_lane_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor1,
  input  logic       sensor2,
  input  logic       sensor3,
  input  logic       rd_done,
  input  logic       rd_ok,
  output logic       rd_start,
  output logic [1:0] rd_lane,
  output logic       busy,
  output logic [2:0] gate_open,
  output logic [2:0] violation,
  output logic [1:0] pend1,
  output logic [1:0] pend2,
  output logic [1:0] pend3,
  output logic [2:0] overflow
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESULT} state_t;

  state_t          state_q;
  logic [2:0]      sens;
  logic [2:0]      sens_prev_q;
  logic [2:0]      arrival;
  logic [2:0]      elig;
  logic [2:0]      grant;
  logic [1:0]      sel_lane;
  logic [2:0][1:0] pend_q, pend_d;
  logic [2:0]      ovf_q, ovf_d;
  logic [1:0]      ptr_q;
  logic [1:0]      lane_q;
  logic            rd_start_q;
  logic            busy_q;
  logic [2:0]      gate_q;
  logic [2:0]      viol_q;

`ifdef TOLL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt_q;
`endif

  // Search starts at the lane after the last grant and wraps 3 -> 1.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] el);
    rr_pick = 2'd0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (int'(ptr) + k) % 3;
      if (rr_pick == 2'd0 && el[idx]) rr_pick = 2'(idx + 1);
    end
  endfunction

  function automatic logic [2:0] lane_bit(input logic [1:0] lane);
    lane_bit = 3'b001 << (lane - 2'd1);
  endfunction

  assign sens     = {sensor3, sensor2, sensor1};
  assign arrival  = sens & ~sens_prev_q;
  assign elig     = {pend_q[2] != 2'd0, pend_q[1] != 2'd0, pend_q[0] != 2'd0};
  assign sel_lane = rr_pick(ptr_q, elig);
  assign grant    = (state_q == S_IDLE && sel_lane != 2'd0) ? lane_bit(sel_lane) : 3'b000;

  // An arrival coinciding with a grant on the same lane cancels out.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < 3; i++) begin
      if (arrival[i] && !grant[i]) begin
        if (pend_q[i] == 2'd3) ovf_d[i] = 1'b1;
        else                   pend_d[i] = pend_q[i] + 2'd1;
      end else if (grant[i] && !arrival[i]) begin
        pend_d[i] = pend_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sens_prev_q <= 3'b000;
      pend_q      <= '0;
      ovf_q       <= 3'b000;
      ptr_q       <= 2'd3;
      lane_q      <= 2'd0;
      rd_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      gate_q      <= 3'b000;
      viol_q      <= 3'b000;
`ifdef TOLL_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      sens_prev_q <= sens;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      rd_start_q  <= 1'b0;
      gate_q      <= 3'b000;
      viol_q      <= 3'b000;
      case (state_q)
        S_IDLE: begin
          if (sel_lane != 2'd0) begin
            state_q    <= S_START;
            lane_q     <= sel_lane;
            ptr_q      <= sel_lane;
            rd_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
`ifdef TOLL_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          // The result pulse is registered on entry to RESULT so it lines up with that state.
          if (rd_done) begin
            state_q <= S_RESULT;
            if (rd_ok) gate_q <= lane_bit(lane_q);
            else       viol_q <= lane_bit(lane_q);
          end
`ifdef TOLL_TIMEOUT_EN
          else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_RESULT;
            viol_q  <= lane_bit(lane_q);
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          lane_q  <= 2'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_start  = rd_start_q;
  assign rd_lane   = lane_q;
  assign busy      = busy_q;
  assign gate_open = gate_q;
  assign violation = viol_q;
  assign pend1     = pend_q[0];
  assign pend2     = pend_q[1];
  assign pend3     = pend_q[2];
  assign overflow  = ovf_q;

endmodule

// File: doc/toll_lane_arbiter.md
# toll_lane_arbiter

Shares a single toll-tag reader between the three ETC lanes. Each lane's vehicle sensor queues reader requests in a saturating per-lane pending counter. A round-robin FSM grants the reader to one lane at a time over a start/done handshake. The transaction result drives a one-cycle gate-open or violation pulse for that lane. The block sits between the lane sensors and the shared reader front-end, alongside the per-lane car counters.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 1000: maximum cycles spent in WAIT before the transaction is forced to fail. Must be ≥2.

**Ports**
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sensor1`, `sensor2`, `sensor3`  in  1 each  lane vehicle-presence sensor, level, already synchronous to `clk`.
- `rd_done`  in  1  reader finished the current transaction; sampled only in WAIT.
- `rd_ok`  in  1  reader result, valid with `rd_done`: 1 = valid tag/paid, 0 = fail.
- `rd_start`  out  1  one-cycle pulse that starts a reader transaction.
- `rd_lane`  out  2  granted lane, encoded 2'd1..2'd3; 2'd0 when idle.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `gate_open`  out  3  one-cycle pulse; bit i-1 = lane i passed.
- `violation`  out  3  one-cycle pulse; bit i-1 = lane i failed or timed out.
- `pend1`, `pend2`, `pend3`  out  2 each  pending request count per lane.
- `overflow`  out  3  sticky flag: bit i-1 = an arrival on lane i was dropped at saturation.

## Operation

**Arrival detect**
- Per lane, register the previous sensor value; an arrival is `sensor` = 1 with previous = 0.
- Previous-value registers reset to 0, so a sensor already high after reset counts as one arrival.

**Pending counters**
- Arrival only: +1. Grant only: −1.
- Arrival and grant on the same lane in the same cycle: no change.
- Arrival at 3 with no grant: counter stays at 3 and the lane's `overflow` bit sets. Only `reset` clears `overflow`.

**Round-robin grant**
- A last-grant pointer resets to lane 3, so lane 1 has first priority out of reset.
- The search order starts at the lane after the last grant and wraps 3→1.
- Only lanes with pend > 0 are eligible.

**FSM states**
- IDLE: if any lane is eligible, latch the chosen lane into `rd_lane`, decrement its pend, update the pointer, go to START. Otherwise stay.
- START: `rd_start` = 1, timeout counter cleared, go to WAIT. `rd_done` is ignored in this state.
- WAIT: if `rd_done`, latch `rd_ok` and go to RESULT. Else if the timeout expires, latch fail and go to RESULT. Else stay and count.
- RESULT: pulse `gate_open[lane]` if the latched result is ok, else pulse `violation[lane]`. Go to IDLE.

**Outputs**
- `rd_start`, `gate_open`, `violation` are Moore outputs decoded from the state.
- `rd_lane` holds its value from START through RESULT and is 0 in IDLE.

**Reset**
- Reset values: state IDLE; all pend = 0; `overflow` = 0; `rd_lane` = 0; `rd_start`, `busy`, `gate_open`, `violation` = 0; pointer = lane 3.
- Reset during any state abandons the transaction. No `gate_open` or `violation` pulse is emitted for it.

## Timing

- Sensor rises at cycle N (low at N−1): pend is incremented and visible at N+1.
- IDLE sees eligible pend at cycle t: START at t+1 with `rd_start` = 1; WAIT at t+2.
- `rd_done` sampled at cycle w in WAIT: RESULT at w+1 with the result pulse; IDLE at w+2.
- Minimum transaction: 4 cycles from grant decision to back in IDLE. The next grant decision is made in the IDLE cycle itself.
- Timeout:
  - The counter counts the cycles spent in WAIT.
  - If WAIT has lasted `TIMEOUT_CYCLES` cycles without `rd_done`, RESULT follows with fail, so WAIT lasts at most `TIMEOUT_CYCLES` cycles.
  - If `rd_done` and timeout expiry occur in the same cycle, `rd_done` wins.
- `busy` = 1 exactly in START, WAIT and RESULT.

## Configuration

- Macro `TOLL_TIMEOUT_EN`.
- Defined: the timeout counter and forced-fail path are built as described above.
- Undefined:
  - WAIT exits only on `rd_done`; no timeout counter exists.
  - `TIMEOUT_CYCLES` is ignored.
  - `violation` fires only on `rd_done` with `rd_ok` = 0.

## Test plan

- Reset, then hold `sensor1` high → `pend1` = 1 one cycle later. Grant lane 1 → `rd_start` pulse with `rd_lane` = 1. Then `rd_done` = 1 with `rd_ok` = 1 in WAIT → `gate_open` = 3'b001 for one cycle. `pend1` = 0 afterwards.
- Raise all three sensors in the same cycle with the reader answering immediately → grants in order lane 1, 2, 3. Next arrivals on lanes 1 and 3 after lane 3's grant → lane 1 granted first.
- Four `sensor2` arrivals while the reader is stalled → `pend2` saturates at 3 and `overflow` = 3'b010.
- `sensor1` arrival in the same cycle as lane 1 is granted from pend = 1 → `pend1` stays 1.
- With `TOLL_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, no `rd_done` → `violation` pulse for the granted lane after 8 WAIT cycles. `rd_done` in the 8th WAIT cycle → normal result instead.
- Assert `reset` while in WAIT → next cycle everything is 0/IDLE, and no result pulse appears.
